// File: rtl/wdt_cfg_pkg.sv
// ============================================================================
//  Module      : wdt_cfg_pkg
//  Description : Shared types and constants for the watchdog configuration
//                sequencer (command address map, FSM states, command record).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wdt_cfg_pkg;

    localparam int WDT_DATA_W = 32;

    // Register address map seen by the CPU-side command port
    typedef enum logic [1:0] {
        WDT_ADDR_EN    = 2'd0,
        WDT_ADDR_LIVE  = 2'd1,
        WDT_ADDR_TOCNT = 2'd2,
        WDT_ADDR_RSVD  = 2'd3
    } wdt_addr_e;

    // Replay FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } seq_state_e;

    // One queued register-write command
    typedef struct packed {
        wdt_addr_e               addr;
        logic [WDT_DATA_W-1:0]   wdata;
    } wdt_cmd_t;

endpackage

`default_nettype wire

// File: rtl/wdt_cmd_fifo.sv
// ============================================================================
//  Module      : wdt_cmd_fifo
//  Description : Synchronous command FIFO. Head is presented combinationally;
//                a push into a full FIFO is ignored even if a pop happens on
//                the same edge, and an empty FIFO never bypasses push data.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wdt_cmd_fifo
    import wdt_cfg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  wdt_cmd_t push_data,
    input  logic     pop,
    output wdt_cmd_t head,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wdt_cmd_t            r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                w_push;
    logic                w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign head   = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    // Storage array; contents need no reset because occupancy gates reads
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/wdt_cfg_sequencer.sv
// ============================================================================
//  Module      : wdt_cfg_sequencer
//  Description : Queues CPU register writes, validates them against the
//                watchdog programming rules and replays accepted ones as
//                data + one-cycle RVALID strobes with a minimum spacing.
//                Optional macro WDT_CFG_LOCK_EN: once WDEN=1 is accepted,
//                WDEN=0 and WTOCNT writes are rejected until reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wdt_cfg_sequencer
    import wdt_cfg_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic        WDEN,
    output logic        WDLIVE,
    output logic [31:0] WTOCNT,
    output logic        WDEN_RVALID,
    output logic        WDLIVE_RVALID,
    output logic        WTOCNT_RVALID,
    output logic        en_o,
    output logic [31:0] tocnt_o,
    output logic        busy
);

    // A zero-cycle gap still needs a legal one-bit counter declaration
    localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] c_gap = CNT_W'(GAP_CYCLES);

    seq_state_e          r_state;
    logic [CNT_W-1:0]    r_gap_cnt;
    logic                r_tocnt_written;
    logic                r_en;
    logic [31:0]         r_tocnt;
    logic                r_live;
    logic                r_en_rv;
    logic                r_live_rv;
    logic                r_tocnt_rv;
    logic                r_rsp_valid;
    logic                r_rsp_err;

    wdt_cmd_t            w_push_cmd;
    wdt_cmd_t            w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_accept;
    logic                w_lock;

    assign w_push_cmd = '{addr: wdt_addr_e'(cmd_addr), wdata: cmd_wdata};
    assign w_pop      = (r_state == IDLE) && !w_empty;

    wdt_cmd_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data (w_push_cmd),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

`ifdef WDT_CFG_LOCK_EN
    logic r_lock;
    assign w_lock = r_lock;

    // Lock latches on the first accepted WDEN=1 and only reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock <= 1'b0;
        end else if (w_pop && w_accept && (w_head.addr == WDT_ADDR_EN) && w_head.wdata[0]) begin
            r_lock <= 1'b1;
        end
    end
`else
    assign w_lock = 1'b0;
`endif

    // Validate the FIFO head against the current programmed state
    always_comb begin
        w_accept = 1'b0;
        case (w_head.addr)
            WDT_ADDR_EN:    w_accept = !(w_head.wdata[0] && !r_tocnt_written)
                                       && !(w_lock && !w_head.wdata[0]);
            WDT_ADDR_LIVE:  w_accept = r_en;
            WDT_ADDR_TOCNT: w_accept = !w_lock;
            default:        w_accept = 1'b0;
        endcase
    end

    // Replay FSM: pop in IDLE, one-cycle strobe/response in ISSUE, then spacing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_gap_cnt       <= '0;
            r_tocnt_written <= 1'b0;
            r_en            <= 1'b0;
            r_tocnt         <= '0;
            r_live          <= 1'b0;
            r_en_rv         <= 1'b0;
            r_live_rv       <= 1'b0;
            r_tocnt_rv      <= 1'b0;
            r_rsp_valid     <= 1'b0;
            r_rsp_err       <= 1'b0;
        end else begin
            // Strobes, kick data and response are single-cycle pulses
            r_en_rv     <= 1'b0;
            r_live_rv   <= 1'b0;
            r_tocnt_rv  <= 1'b0;
            r_live      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_state     <= ISSUE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= !w_accept;
                        if (w_accept) begin
                            case (w_head.addr)
                                WDT_ADDR_EN: begin
                                    r_en_rv <= 1'b1;
                                    r_en    <= w_head.wdata[0];
                                end
                                WDT_ADDR_LIVE: begin
                                    r_live_rv <= 1'b1;
                                    r_live    <= w_head.wdata[0];
                                end
                                WDT_ADDR_TOCNT: begin
                                    r_tocnt_rv      <= 1'b1;
                                    r_tocnt         <= w_head.wdata;
                                    r_tocnt_written <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ISSUE: begin
                    if (GAP_CYCLES > 0) begin
                        r_state   <= GAP;
                        r_gap_cnt <= c_gap;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                GAP: begin
                    if (r_gap_cnt <= CNT_W'(1)) r_state <= IDLE;
                    else                        r_gap_cnt <= r_gap_cnt - CNT_W'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready     = !w_full;
    assign busy          = !w_empty || (r_state != IDLE);
    assign rsp_valid     = r_rsp_valid;
    assign rsp_err       = r_rsp_err;
    assign WDEN          = r_en;
    assign en_o          = r_en;
    assign WTOCNT        = r_tocnt;
    assign tocnt_o       = r_tocnt;
    assign WDLIVE        = r_live;
    assign WDEN_RVALID   = r_en_rv;
    assign WDLIVE_RVALID = r_live_rv;
    assign WTOCNT_RVALID = r_tocnt_rv;

endmodule

`default_nettype wire
